// File: rtl/trap_ctrl.sv
// Trap controller: picks one trap per instruction boundary by fixed priority,
// strobes it into the CSR file for one cycle, flushes, then stalls while the front end redirects.
module trap_ctrl #(
    parameter int XLEN         = 32,
    parameter int SYNC_STAGES  = 2,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            instr_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            exc_valid,
    input  logic [4:0]      exc_cause,
    input  logic            mret_i,
    input  logic            sret_i,
    input  logic            pipe_stall,
    input  logic            m_ext_irq,
    input  logic            s_ext_irq,
    input  logic            m_timer,
    input  logic            s_timer,
    input  logic            m_eie,
    input  logic            m_tie,
    input  logic            s_eie,
    input  logic            s_tie,
    output logic            exception_pending,
    output logic [XLEN-1:0] m_cause,
    output logic [XLEN-1:0] pc_exc,
    output logic            m_ret,
    output logic            s_ret,
    output logic            m_interrupt,
    output logic            s_interrupt,
    output logic            flush,
    output logic            trap_stall
);

    typedef enum logic [1:0] {IDLE, TRAP, DRAIN} state_t;

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [XLEN-1:0] IRQ_BIT   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] CAUSE_MEI = IRQ_BIT | XLEN'(11);
    localparam logic [XLEN-1:0] CAUSE_MTI = IRQ_BIT | XLEN'(7);
    localparam logic [XLEN-1:0] CAUSE_SEI = IRQ_BIT | XLEN'(9);
    localparam logic [XLEN-1:0] CAUSE_STI = IRQ_BIT | XLEN'(5);

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [SYNC_STAGES-1:0] m_sync, s_sync;
    logic [XLEN-1:0] cause_q, pc_q;
    logic            mret_q, sret_q;

    logic            req_any, sel_mret, sel_sret, take, load;
    logic [XLEN-1:0] sel_cause;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_sync <= '0;
            s_sync <= '0;
        end else begin
            m_sync <= {m_sync[SYNC_STAGES-2:0], m_ext_irq};
            s_sync <= {s_sync[SYNC_STAGES-2:0], s_ext_irq};
        end
    end

    assign m_interrupt = m_sync[SYNC_STAGES-1];
    assign s_interrupt = s_sync[SYNC_STAGES-1];

    // Interrupts outrank the instruction in execute; its own exception/xRET is dropped
    always_comb begin
        req_any   = 1'b1;
        sel_cause = '0;
        sel_mret  = 1'b0;
        sel_sret  = 1'b0;
        if (m_interrupt && m_eie)      sel_cause = CAUSE_MEI;
        else if (m_timer && m_tie)     sel_cause = CAUSE_MTI;
        else if (s_interrupt && s_eie) sel_cause = CAUSE_SEI;
        else if (s_timer && s_tie)     sel_cause = CAUSE_STI;
        else if (exc_valid)            sel_cause = XLEN'(exc_cause);
        else if (mret_i)               sel_mret  = 1'b1;
        else if (sret_i)               sel_sret  = 1'b1;
        else                           req_any   = 1'b0;
    end

    assign take = (state == IDLE) && instr_valid && !pipe_stall;
    assign load = take && req_any;

    always_comb begin
        state_next        = state;
        cnt_next          = cnt;
        exception_pending = 1'b0;
        flush             = 1'b0;
        trap_stall        = 1'b0;
        case (state)
            IDLE: begin
                if (load) state_next = TRAP;
            end
            TRAP: begin
                exception_pending = 1'b1;
                flush             = 1'b1;
                state_next        = DRAIN;
                cnt_next          = CW'(DRAIN_CYCLES - 1);
            end
            DRAIN: begin
                trap_stall = 1'b1;
                if (cnt == '0) state_next = IDLE;
                else           cnt_next   = cnt - CW'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            cnt     <= '0;
            cause_q <= '0;
            pc_q    <= '0;
            mret_q  <= 1'b0;
            sret_q  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (load) begin
                cause_q <= sel_cause;
                pc_q    <= ex_pc;
                mret_q  <= sel_mret;
                sret_q  <= sel_sret;
            end
        end
    end

    assign m_cause = cause_q;
    assign pc_exc  = pc_q;
    assign m_ret   = exception_pending && mret_q;
    assign s_ret   = exception_pending && sret_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a trap-window reference model.
module tb_trap_ctrl;

    localparam int XLEN = 32;
    localparam int S    = 2;
    localparam int D    = 2;

    logic            clk = 1'b0;
    logic            nrst;
    logic            instr_valid, exc_valid, mret_i, sret_i, pipe_stall;
    logic [XLEN-1:0] ex_pc;
    logic [4:0]      exc_cause;
    logic            m_ext_irq, s_ext_irq, m_timer, s_timer;
    logic            m_eie, m_tie, s_eie, s_tie;
    logic            exception_pending, m_ret, s_ret, m_interrupt, s_interrupt;
    logic            flush, trap_stall;
    logic [XLEN-1:0] m_cause, pc_exc;

    int total_cnt = 0;
    int pass_cnt  = 0;

    trap_ctrl #(.XLEN(XLEN), .SYNC_STAGES(S), .DRAIN_CYCLES(D)) dut (
        .clk(clk), .nrst(nrst), .instr_valid(instr_valid), .ex_pc(ex_pc),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .mret_i(mret_i), .sret_i(sret_i),
        .pipe_stall(pipe_stall), .m_ext_irq(m_ext_irq), .s_ext_irq(s_ext_irq),
        .m_timer(m_timer), .s_timer(s_timer), .m_eie(m_eie), .m_tie(m_tie),
        .s_eie(s_eie), .s_tie(s_tie), .exception_pending(exception_pending),
        .m_cause(m_cause), .pc_exc(pc_exc), .m_ret(m_ret), .s_ret(s_ret),
        .m_interrupt(m_interrupt), .s_interrupt(s_interrupt), .flush(flush),
        .trap_stall(trap_stall)
    );

    always #5 clk = ~clk;

    // Reference model: a trap opens a window of 1+D cycles (TRAP then D stall cycles)
    int              mdl_left;
    logic [XLEN-1:0] mdl_cause, mdl_pc;
    logic            mdl_mret, mdl_sret;
    logic [S-1:0]    m_hist, s_hist;
    logic            exp_mint, exp_sint, want_any, want_mret, want_sret;
    logic [XLEN-1:0] want_cause;

    assign exp_mint = m_hist[S-1];
    assign exp_sint = s_hist[S-1];

    always_comb begin
        want_any   = 1'b1;
        want_cause = '0;
        want_mret  = 1'b0;
        want_sret  = 1'b0;
        if (exp_mint && m_eie)      want_cause = 32'h8000_000B;
        else if (m_timer && m_tie)  want_cause = 32'h8000_0007;
        else if (exp_sint && s_eie) want_cause = 32'h8000_0009;
        else if (s_timer && s_tie)  want_cause = 32'h8000_0005;
        else if (exc_valid)         want_cause = {27'b0, exc_cause};
        else if (mret_i)            want_mret  = 1'b1;
        else if (sret_i)            want_sret  = 1'b1;
        else                        want_any   = 1'b0;
    end

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mdl_left  <= 0;
            mdl_cause <= '0;
            mdl_pc    <= '0;
            mdl_mret  <= 1'b0;
            mdl_sret  <= 1'b0;
            m_hist    <= '0;
            s_hist    <= '0;
        end else begin
            if (mdl_left > 0) begin
                mdl_left <= mdl_left - 1;
            end else if (instr_valid && !pipe_stall && want_any) begin
                mdl_left  <= 1 + D;
                mdl_cause <= want_cause;
                mdl_pc    <= ex_pc;
                mdl_mret  <= want_mret;
                mdl_sret  <= want_sret;
            end
            m_hist <= {m_hist[S-2:0], m_ext_irq};
            s_hist <= {s_hist[S-2:0], s_ext_irq};
        end
    end

    task automatic checkOutput(input string name, input logic [XLEN-1:0] act,
                               input logic [XLEN-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Every cycle, compare all outputs against the model
    always @(negedge clk) begin
        logic in_trap;
        in_trap = (mdl_left == 1 + D);
        checkOutput("pending", {31'b0, exception_pending}, {31'b0, in_trap});
        checkOutput("flush", {31'b0, flush}, {31'b0, in_trap});
        checkOutput("stall", {31'b0, trap_stall}, {31'b0, (mdl_left >= 1 && mdl_left <= D)});
        checkOutput("m_ret", {31'b0, m_ret}, {31'b0, in_trap && mdl_mret});
        checkOutput("s_ret", {31'b0, s_ret}, {31'b0, in_trap && mdl_sret});
        checkOutput("m_cause", m_cause, mdl_cause);
        checkOutput("pc_exc", pc_exc, mdl_pc);
        checkOutput("m_int", {31'b0, m_interrupt}, {31'b0, exp_mint});
        checkOutput("s_int", {31'b0, s_interrupt}, {31'b0, exp_sint});
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clearInputs();
        instr_valid = 0; exc_valid = 0; mret_i = 0; sret_i = 0; pipe_stall = 0;
        ex_pc = '0; exc_cause = '0; m_ext_irq = 0; s_ext_irq = 0;
        m_timer = 0; s_timer = 0; m_eie = 0; m_tie = 0; s_eie = 0; s_tie = 0;
    endtask

    task automatic applyStimulus(input bit allow_reset);
        instr_valid = ($urandom_range(99) < 75);
        pipe_stall  = ($urandom_range(99) < 20);
        exc_valid   = ($urandom_range(99) < 20);
        exc_cause   = 5'($urandom_range(15));
        mret_i      = ($urandom_range(99) < 10);
        sret_i      = ($urandom_range(99) < 10);
        ex_pc       = {$urandom} & 32'hFFFF_FFFC;
        if ($urandom_range(99) < 6)  m_ext_irq = ~m_ext_irq;
        if ($urandom_range(99) < 6)  s_ext_irq = ~s_ext_irq;
        if ($urandom_range(99) < 5)  m_timer   = ~m_timer;
        if ($urandom_range(99) < 5)  s_timer   = ~s_timer;
        if ($urandom_range(99) < 10) m_eie     = ~m_eie;
        if ($urandom_range(99) < 10) m_tie     = ~m_tie;
        if ($urandom_range(99) < 10) s_eie     = ~s_eie;
        if ($urandom_range(99) < 10) s_tie     = ~s_tie;
        if (allow_reset) nrst = ($urandom_range(199) != 0);
    endtask

    initial begin
        nrst = 0;
        clearInputs();

        // Reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            step();
            applyStimulus(1'b0);
        end
        checkOutput("rst_pending", {31'b0, exception_pending}, 32'd0);
        checkOutput("rst_stall", {31'b0, trap_stall}, 32'd0);
        checkOutput("rst_cause", m_cause, 32'd0);
        checkOutput("rst_mint", {31'b0, m_interrupt}, 32'd0);
        clearInputs();
        nrst = 1;
        repeat (3) step();
        checkOutput("idle_pending", {31'b0, exception_pending}, 32'd0);

        // Illegal instruction
        instr_valid = 1; ex_pc = 32'h100; exc_valid = 1; exc_cause = 5'd2;
        step();
        checkOutput("ill_pending", {31'b0, exception_pending}, 32'd1);
        checkOutput("ill_flush", {31'b0, flush}, 32'd1);
        checkOutput("ill_cause", m_cause, 32'h0000_0002);
        checkOutput("ill_pc", pc_exc, 32'h100);
        clearInputs();
        step();
        checkOutput("ill_drain1", {31'b0, trap_stall}, 32'd1);
        checkOutput("ill_drain1_pend", {31'b0, exception_pending}, 32'd0);
        step();
        checkOutput("ill_drain2", {31'b0, trap_stall}, 32'd1);
        step();
        checkOutput("ill_idle", {31'b0, trap_stall}, 32'd0);
        checkOutput("ill_cause_hold", m_cause, 32'h0000_0002);

        // Timer interrupt pre-empts exception in the same cycle
        m_tie = 1; m_timer = 1; instr_valid = 1; exc_valid = 1; exc_cause = 5'd5; ex_pc = 32'h200;
        step();
        checkOutput("mti_cause", m_cause, 32'h8000_0007);
        checkOutput("mti_pc", pc_exc, 32'h200);
        clearInputs();
        repeat (3) step();

        // Priority with synchroniser latency: STI first, then MEI
        m_eie = 1; m_ext_irq = 1; s_timer = 1; s_tie = 1; instr_valid = 1; ex_pc = 32'h300;
        step();
        checkOutput("sti_cause", m_cause, 32'h8000_0005);
        checkOutput("sync_lat1", {31'b0, m_interrupt}, 32'd0);
        s_timer = 0;
        step();
        checkOutput("sync_lat2", {31'b0, m_interrupt}, 32'd1);
        step();
        step();
        checkOutput("b2b_idle", {31'b0, exception_pending}, 32'd0);
        step();
        checkOutput("mei_pending", {31'b0, exception_pending}, 32'd1);
        checkOutput("mei_cause", m_cause, 32'h8000_000B);
        clearInputs();
        repeat (4) step();

        // MRET, then exceptions during DRAIN are ignored
        instr_valid = 1; mret_i = 1; ex_pc = 32'h400;
        step();
        checkOutput("mret_pending", {31'b0, exception_pending}, 32'd1);
        checkOutput("mret_m", {31'b0, m_ret}, 32'd1);
        checkOutput("mret_s", {31'b0, s_ret}, 32'd0);
        checkOutput("mret_cause", m_cause, 32'd0);
        mret_i = 0; exc_valid = 1; exc_cause = 5'd3;
        step();
        checkOutput("drain_ign1", {31'b0, exception_pending}, 32'd0);
        step();
        checkOutput("drain_ign2", {31'b0, exception_pending}, 32'd0);
        clearInputs();
        step();
        step();
        checkOutput("drain_ign3", {31'b0, exception_pending}, 32'd0);

        // Stall holds off the trap; reset mid-DRAIN clears everything
        instr_valid = 1; exc_valid = 1; exc_cause = 5'd4; pipe_stall = 1; ex_pc = 32'h500;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("stall_hold", {31'b0, exception_pending}, 32'd0);
        end
        pipe_stall = 0;
        step();
        checkOutput("stall_take", m_cause, 32'h0000_0004);
        clearInputs();
        step();
        checkOutput("pre_rst_stall", {31'b0, trap_stall}, 32'd1);
        nrst = 0;
        #1;
        checkOutput("rst_drain_stall", {31'b0, trap_stall}, 32'd0);
        checkOutput("rst_drain_cause", m_cause, 32'd0);
        step();
        nrst = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("post_rst", {31'b0, exception_pending | trap_stall}, 32'd0);
        end

        // Randomized traffic, checked by the per-cycle compare process
        for (int i = 0; i < 3000; i++) begin
            step();
            applyStimulus(1'b1);
        end
        nrst = 1;
        clearInputs();
        repeat (5) step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
